// File: rtl/input_debounce.sv
// Two-flop synchronizer followed by a full-word debouncer. A new word is
// committed to data_out only after the synchronized input has held the same
// value for G_STABLE consecutive clocks. valid pulses once per commit.
module input_debounce #(
  parameter int unsigned G_WIDTH  = 7,
  parameter int unsigned G_STABLE = 4   // legal range 2..255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [G_WIDTH-1:0] data_in,
  output logic [G_WIDTH-1:0] data_out,
  output logic               valid,
  output logic               busy
);

  localparam int unsigned CW = $clog2(G_STABLE + 1);
  // The counter reaches G_STABLE-1 on the last settling sample and commits there.
  localparam logic [CW-1:0] CNT_LAST = CW'(G_STABLE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [G_WIDTH-1:0] sync1_q, sync1_d;
  logic [G_WIDTH-1:0] sync2_q, sync2_d;
  logic [G_WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [G_WIDTH-1:0] data_out_q, data_out_d;
  logic               valid_q, valid_d;

  // Next-state logic: synchronizer shift plus the IDLE/SETTLE debounce FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    sync1_d    = data_in;
    sync2_d    = sync1_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (sync2_q != data_out_q) begin
          cand_d  = sync2_q;
          cnt_d   = CNT_ONE;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sync2_q == data_out_q) begin
          // Input fell back to the committed word: drop the candidate.
          state_d = IDLE;
        end else if (sync2_q != cand_q) begin
          // Any bit change restarts settling on the new word.
          cand_d = sync2_q;
          cnt_d  = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          data_out_d = cand_q;
          valid_d    = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset clears synchronizer, candidate and committed word.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the reset branch covers every flop, so reset mid-settle leaves nothing stale.
    if (!rst_n) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep sync1 -> sync2 a true two-stage shift.
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
  assign busy     = (state_q == SETTLE);

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: default build (G_STABLE=4) and a
// G_STABLE=2 build driven side by side from the same clock and reset.
`timescale 1ns/1ps
module tb_input_debounce;

  logic       clk;
  logic       rst_n;
  logic [6:0] data_in;
  logic [6:0] data_out;
  logic       valid;
  logic       busy;
  logic [6:0] data_in2;
  logic [6:0] data_out2;
  logic       valid2;
  logic       busy2;

  int n_cmp = 0;
  int n_err = 0;
  int n_valid;

  input_debounce #(.G_WIDTH(7), .G_STABLE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .data_out (data_out),
    .valid    (valid),
    .busy     (busy)
  );

  input_debounce #(.G_WIDTH(7), .G_STABLE(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in2),
    .data_out (data_out2),
    .valid    (valid2),
    .busy     (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1. Reset with a nonzero input, then 20 quiet clocks.
    rst_n    = 1'b0;
    data_in  = 7'h55;
    data_in2 = 7'h00;
    #2;
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_valid",    32'(valid),    32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_data_out2", 32'(data_out2), 32'h00);
    tick(); tick(); tick();
    check("rst_hold_data_out", 32'(data_out), 32'h00);
    check("rst_hold_busy",     32'(busy),     32'h0);
    data_in = 7'h00;
    rst_n   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_valid", 32'(valid), 32'h0);
      check("idle_busy",  32'(busy),  32'h0);
    end
    check("idle_data_out", 32'(data_out), 32'h00);

    // 2. Clean step 0 -> 40.
    data_in = 7'h40;
    tick();  // edge 0
    check("step_e0_busy", 32'(busy), 32'h0);
    tick();  // edge 1
    check("step_e1_busy", 32'(busy), 32'h0);
    tick();  // edge 2
    check("step_e2_busy",  32'(busy),  32'h1);
    check("step_e2_valid", 32'(valid), 32'h0);
    tick();  // edge 3
    check("step_e3_busy",  32'(busy),  32'h1);
    check("step_e3_valid", 32'(valid), 32'h0);
    tick();  // edge 4
    check("step_e4_busy",     32'(busy),     32'h1);
    check("step_e4_data_out", 32'(data_out), 32'h00);
    check("step_e4_valid",    32'(valid),    32'h0);
    tick();  // edge 5
    check("step_e5_valid",    32'(valid),    32'h1);
    check("step_e5_data_out", 32'(data_out), 32'h40);
    check("step_e5_busy",     32'(busy),     32'h0);
    tick();  // edge 6
    check("step_e6_valid",    32'(valid),    32'h0);
    check("step_e6_data_out", 32'(data_out), 32'h40);

    // 3. Two-clock glitch to 41 is rejected.
    data_in = 7'h41;
    tick();  // edge 0
    tick();  // edge 1
    check("glitch_e1_busy", 32'(busy), 32'h0);
    data_in = 7'h40;
    tick();  // edge 2: SETTLE on 41
    check("glitch_e2_busy", 32'(busy), 32'h1);
    tick();  // edge 3: still 41 in sync2
    check("glitch_e3_busy", 32'(busy), 32'h1);
    tick();  // edge 4: back to committed value
    check("glitch_e4_busy", 32'(busy), 32'h0);
    n_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid) n_valid++;
    end
    check("glitch_no_valid", 32'(n_valid), 32'h0);
    check("glitch_data_out", 32'(data_out), 32'h40);

    // 4. Bounce 10/11 every 3 clocks for 24 clocks, then hold 11.
    //    Last transition (to 11) is captured at loop edge 21; commit at edge 26.
    n_valid = 0;
    for (int t = 0; t < 24; t++) begin
      data_in = ((t / 3) % 2 == 1) ? 7'h11 : 7'h10;
      tick();
      if (valid) n_valid++;
    end
    check("bounce_no_early_valid", 32'(n_valid), 32'h0);
    check("bounce_hold_data_out", 32'(data_out), 32'h40);
    tick();  // edge 24
    check("bounce_e24_valid", 32'(valid), 32'h0);
    tick();  // edge 25
    check("bounce_e25_valid",    32'(valid),    32'h0);
    check("bounce_e25_data_out", 32'(data_out), 32'h40);
    tick();  // edge 26
    check("bounce_e26_valid",    32'(valid),    32'h1);
    check("bounce_e26_data_out", 32'(data_out), 32'h11);
    n_valid = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid) n_valid++;
    end
    check("bounce_single_valid", 32'(n_valid), 32'h0);
    check("bounce_final", 32'(data_out), 32'h11);

    // 5. Return to 0, then reset in the middle of settling on 7F.
    data_in = 7'h00;
    for (int i = 0; i < 6; i++) tick();
    check("zero_commit", 32'(data_out), 32'h00);
    data_in = 7'h7F;
    tick();  // edge 0
    tick();  // edge 1
    tick();  // edge 2
    check("rms_e2_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rms_async_busy",     32'(busy),     32'h0);
    check("rms_async_valid",    32'(valid),    32'h0);
    check("rms_async_data_out", 32'(data_out), 32'h00);
    tick();  // edge held in reset
    check("rms_hold_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();  // edges 0..3 after release
      if (valid) n_valid++;
    end
    check("rms_no_early_valid", 32'(n_valid), 32'h0);
    tick();  // edge 4
    check("rms_e4_valid", 32'(valid), 32'h0);
    check("rms_e4_busy",  32'(busy),  32'h1);
    tick();  // edge 5
    check("rms_e5_valid",    32'(valid),    32'h1);
    check("rms_e5_data_out", 32'(data_out), 32'h7F);

    // 6. G_STABLE=2 build: step 0 -> 03 commits at edge 3.
    data_in2 = 7'h03;
    tick();  // edge 0
    tick();  // edge 1
    check("g2_e1_busy", 32'(busy2), 32'h0);
    tick();  // edge 2
    check("g2_e2_busy",  32'(busy2),  32'h1);
    check("g2_e2_valid", 32'(valid2), 32'h0);
    tick();  // edge 3
    check("g2_e3_valid",    32'(valid2),    32'h1);
    check("g2_e3_data_out", 32'(data_out2), 32'h03);
    tick();  // edge 4
    check("g2_e4_valid", 32'(valid2), 32'h0);
    // One-clock glitch to 02 must not commit.
    data_in2 = 7'h02;
    tick();  // edge 0
    data_in2 = 7'h03;
    tick();  // edge 1
    tick();  // edge 2: SETTLE on 02
    check("g2_glitch_busy", 32'(busy2), 32'h1);
    n_valid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid2) n_valid++;
    end
    check("g2_glitch_no_valid", 32'(n_valid),   32'h0);
    check("g2_glitch_data_out", 32'(data_out2), 32'h03);
    check("g2_glitch_idle",     32'(busy2),     32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
# input_debounce

Conditions the raw 7-bit switch/pad word before it enters the square-root pipeline. Each bit passes through a two-flop synchronizer, then the whole word is debounced: a new value is committed only after it has been sampled identically for `G_STABLE` consecutive clocks. Pads `io_in[7:1]` drive `data_in`. The committed `data_out` feeds the square-root stage, zero-extended to 8 bits. `valid` marks each committed update for downstream consumers.

## Interface

- `G_WIDTH`, default 7: width of the conditioned word.
- `G_STABLE`, default 4: consecutive identical synchronized samples required to commit. Legal range 2..255.
- `clk`  in  1: single clock (pad `io_in[0]`). All state is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data_in`  in  `G_WIDTH`: raw, asynchronous input word.
- `data_out`  out  `G_WIDTH`: debounced, committed word. Registered.
- `valid`  out  1: one-cycle pulse in the cycle `data_out` takes a new value. Registered.
- `busy`  out  1: high while a candidate differing from `data_out` is settling. Registered.

## Operation

- **Synchronizer:** `sync1 <= data_in`, then `sync2 <= sync1`. The FSM reads only `sync2`.
- **Internal state:**
  - candidate register `cand`, `G_WIDTH` bits;
  - counter `cnt`, width `$clog2(G_STABLE+1)`.
  - `cnt` never exceeds `G_STABLE-1`.
- **FSM state IDLE** (`busy`=0):
  - `sync2 == data_out`: stay, no change.
  - `sync2 != data_out`: `cand <= sync2`, `cnt <= 1`, go to SETTLE.
- **FSM state SETTLE** (`busy`=1). Priority is top to bottom:
  1. `sync2 == data_out` (input returned to the committed value): go to IDLE. No `valid`, `data_out` unchanged.
  2. `sync2 != cand`: `cand <= sync2`, `cnt <= 1`, stay in SETTLE (restart).
  3. `sync2 == cand` and `cnt == G_STABLE-1`: `data_out <= cand`, `valid <= 1`, go to IDLE.
  4. Otherwise `cnt <= cnt + 1`.
- **`valid`:** 0 in every cycle not covered by rule 3. Back-to-back pulses are impossible, because every commit needs at least 2 sampled cycles.
- **`busy`:** equals (state == SETTLE), registered alongside the state.
- **Comparisons:** all are full-word. Any bit change restarts settling.
- **Reset** (async assert, `rst_n`=0): `sync1`, `sync2`, `cand`, `cnt`, `data_out` all 0; `valid`=0, `busy`=0, state IDLE.
  - Reset mid-SETTLE discards the candidate.
  - After release, a nonzero input is treated as a fresh change from 0.
- **Deassertion:** the reset is released synchronously to `clk` outside this block. The block assumes no extra deassertion synchronizer.

## Timing

- **Latency:** a change on `data_in` first captured by `sync1` at edge 0 is committed as follows:
  - `sync2` updates at edge 1;
  - SETTLE is entered at edge 2;
  - `data_out` and `valid` update at edge `G_STABLE+1` (edge 5 at default), if the input is held;
  - `busy` is high from after edge 2 until edge `G_STABLE+1`.
- **Min pulse width:** input pulses shorter than `G_STABLE` clocks after synchronization never reach `data_out`.
- **Throughput:** at most one commit every `G_STABLE` clocks.
- **Downstream:** `data_out` is stable between `valid` pulses. The square-root pipeline may sample it every cycle; its 5-clock latency then adds on top.
- **Multi-bit skew:** a word changing on several bits across adjacent edges is seen as successive candidates. Only the final stable word commits.

## Test plan

1. **Reset:** hold `rst_n`=0 with `data_in`=7'h55 → `data_out`=0, `valid`=0, `busy`=0. Release with `data_in`=0 → outputs stay 0 for 20 clocks, no `valid`.
2. **Clean step:** `data_in` 0 → 7'h40 held (first captured edge 0). Required:
   - `busy`=1 after edges 2..4;
   - `valid`=1 for exactly the cycle after edge 5;
   - `data_out`=7'h40 from edge 5 onward.
3. **Glitch rejection:** with `data_out`=7'h40, drive 7'h41 for 2 clocks, then 7'h40 → `busy` pulses, no `valid`, `data_out` stays 7'h40.
4. **Bounce:** alternate 7'h10/7'h11 every 3 clocks for 24 clocks, then hold 7'h11 → exactly one `valid`, `data_out`=7'h11, at edge `G_STABLE+1` after the last transition is captured.
5. **Reset mid-settle:** step 0 → 7'h7F, assert `rst_n`=0 at edge 3. Required:
   - all outputs 0 immediately (asynchronous);
   - after release with 7'h7F still applied, a `valid` pulse with `data_out`=7'h7F occurs 5 edges after the first capture.
6. **`G_STABLE`=2 build:** step 0 → 7'h03 → commit and `valid` at edge 3. A 1-clock glitch produces no commit.
